// File: rtl/mem_arbiter.sv
// Two-port to one-port line-granular memory arbiter: serialises I-cache and
// D-cache miss/writeback requests onto one downstream port with alternating priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state, state_nxt;
  logic   last_d, last_d_nxt;
  logic   d_req, grant, grant_d, done;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    grant      = 1'b0;
    done       = 1'b0;
    d_req      = d_read | d_write;
    // D wins a tie only when the previous grant went to I
    grant_d    = d_req & (~i_read | ~last_d);
    case (state)
      IDLE: begin
        if (i_read | d_req) begin
          grant      = 1'b1;
          state_nxt  = grant_d ? SERVE_D : SERVE_I;
          last_d_nxt = grant_d;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          i_resp    = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          d_resp    = 1'b1;
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  // Downstream request is latched at grant and held until the response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant) begin
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_write <= d_write;
        mem_read  <= d_read & ~d_write;
      end else begin
        mem_addr  <= i_addr;
        mem_read  <= 1'b1;
        mem_write <= 1'b0;
      end
    end else if (done) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

endmodule
